// File: rtl/audio_voice_allocator.sv
// audio_voice_allocator: assigns note-on/note-off commands to NVOICES
// oscillator voices. Each accepted command walks through the voices one per
// cycle (SCAN), then applies its result on a single COMMIT edge.
// Optional build macro: AUDIO_VOICE_STEAL_EN. When defined, a note-on that
// finds every voice busy steals the oldest voice. When undefined, that note-on
// is discarded and drop pulses for one cycle.
//
// Handshake: a command transfers on a rising edge where cmd_valid=1 and
// cmd_ready=1. cmd_ready is high only in IDLE. While SCAN/COMMIT run, cmd_valid
// and all cmd_* inputs are ignored.
module audio_voice_allocator #(
  parameter int NVOICES = 4,
  parameter int AGEBITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_note_on,
  input  logic [6:0]              cmd_note,
  input  logic [15:0]             cmd_increment,
  input  logic [3:0]              cmd_waveform,
  output logic [16*NVOICES-1:0]   voice_increment,
  output logic [4*NVOICES-1:0]    voice_select,
  output logic [NVOICES-1:0]      voice_gate,
  output logic                    drop,
  output logic [1:0]              dbg_state
);

  localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NVOICES - 1);
  localparam logic [AGEBITS-1:0] AGE_MAX = {AGEBITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   accept;

  // Latched command fields
  logic        on_q;
  logic [6:0]  note_q;
  logic [15:0] inc_q;
  logic [3:0]  wf_q;

  // Scan walker and its findings
  logic [IW-1:0] idx_q;
  logic          hit_q;
  logic [IW-1:0] hit_idx_q;
  logic          free_q;
  logic [IW-1:0] free_idx_q;
`ifdef AUDIO_VOICE_STEAL_EN
  logic               old_valid_q;
  logic [IW-1:0]      old_idx_q;
  logic [AGEBITS-1:0] old_age_q;
`endif

  // Per-voice state
  logic [15:0]        v_inc_q  [NVOICES];
  logic [3:0]         v_sel_q  [NVOICES];
  logic [NVOICES-1:0] v_gate_q;
  logic [6:0]         v_note_q [NVOICES];
  logic [AGEBITS-1:0] v_age_q  [NVOICES];
  logic               drop_q;

  // Commit decisions
  logic          do_on;
  logic [IW-1:0] tgt;
  logic          drop_d;

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_ready && cmd_valid;
  assign dbg_state = state_q;
  assign drop      = drop_q;
  assign voice_gate = v_gate_q;

  genvar gi;
  generate
    for (gi = 0; gi < NVOICES; gi++) begin : g_out
      assign voice_increment[16*gi +: 16] = v_inc_q[gi];
      assign voice_select[4*gi +: 4]      = v_sel_q[gi];
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = SCAN;
      SCAN:    if (idx_q == LAST_IDX) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the command on accept and walk the voices during SCAN
  always_ff @(posedge clk) begin
    if (rst) begin
      on_q       <= 1'b0;
      note_q     <= '0;
      inc_q      <= '0;
      wf_q       <= '0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      free_q     <= 1'b0;
      free_idx_q <= '0;
`ifdef AUDIO_VOICE_STEAL_EN
      old_valid_q <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
`endif
    end else if (accept) begin
      on_q       <= cmd_note_on;
      note_q     <= cmd_note;
      inc_q      <= cmd_increment;
      wf_q       <= cmd_waveform;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      free_q     <= 1'b0;
`ifdef AUDIO_VOICE_STEAL_EN
      old_valid_q <= 1'b0;
`endif
    end else if (state_q == SCAN) begin
      // First gated voice holding the same note wins a retrigger
      if (v_gate_q[idx_q] && (v_note_q[idx_q] == note_q) && !hit_q) begin
        hit_q     <= 1'b1;
        hit_idx_q <= idx_q;
      end
      // First ungated voice is the free slot
      if (!v_gate_q[idx_q] && !free_q) begin
        free_q     <= 1'b1;
        free_idx_q <= idx_q;
      end
`ifdef AUDIO_VOICE_STEAL_EN
      // Strictly greater keeps the lowest index on age ties
      if (v_gate_q[idx_q] && (!old_valid_q || (v_age_q[idx_q] > old_age_q))) begin
        old_valid_q <= 1'b1;
        old_idx_q   <= idx_q;
        old_age_q   <= v_age_q[idx_q];
      end
`endif
      if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
    end
  end

  // Pick the note-on target (or decide to drop) from the scan findings
  always_comb begin
    do_on  = 1'b0;
    tgt    = '0;
    drop_d = 1'b0;
    if ((state_q == COMMIT) && on_q) begin
      if (hit_q) begin
        do_on = 1'b1;
        tgt   = hit_idx_q;
      end else if (free_q) begin
        do_on = 1'b1;
        tgt   = free_idx_q;
      end else begin
`ifdef AUDIO_VOICE_STEAL_EN
        do_on = 1'b1;
        tgt   = old_idx_q;
`else
        drop_d = 1'b1;
`endif
      end
    end
  end

  // Voice state update, only on the COMMIT edge
  always_ff @(posedge clk) begin
    if (rst) begin
      v_gate_q <= '0;
      drop_q   <= 1'b0;
      for (int i = 0; i < NVOICES; i++) begin
        v_inc_q[i]  <= '0;
        v_sel_q[i]  <= '0;
        v_note_q[i] <= '0;
        v_age_q[i]  <= '0;
      end
    end else begin
      drop_q <= drop_d;
      if (state_q == COMMIT) begin
        for (int i = 0; i < NVOICES; i++) begin
          if (on_q) begin
            if (do_on && (tgt == IW'(i))) begin
              v_gate_q[i] <= 1'b1;
              v_inc_q[i]  <= inc_q;
              v_sel_q[i]  <= wf_q;
              v_note_q[i] <= note_q;
              v_age_q[i]  <= '0;
            end else if (do_on && v_gate_q[i] && (v_age_q[i] != AGE_MAX)) begin
              v_age_q[i] <= v_age_q[i] + 1'b1;
            end
          end else if (v_gate_q[i] && (v_note_q[i] == note_q)) begin
            // Note-off silences the voice; increment and note are kept
            v_gate_q[i] <= 1'b0;
            v_sel_q[i]  <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_voice_allocator.sv
// Testbench for audio_voice_allocator: directed scenarios followed by
// randomized commands, all compared against a behavioural voice model.
module tb_audio_voice_allocator;

  localparam int NV      = 4;
  localparam int AGEBITS = 3;
  localparam int MAXAGE  = (1 << AGEBITS) - 1;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_note_on;
  logic [6:0]        cmd_note;
  logic [15:0]       cmd_increment;
  logic [3:0]        cmd_waveform;
  logic [16*NV-1:0]  voice_increment;
  logic [4*NV-1:0]   voice_select;
  logic [NV-1:0]     voice_gate;
  logic              drop;
  logic [1:0]        dbg_state;

  int checks;
  int failures;

  // Behavioural model of the voice bank
  bit m_gate [NV];
  int m_note [NV];
  int m_inc  [NV];
  int m_sel  [NV];
  int m_age  [NV];

  audio_voice_allocator #(.NVOICES(NV), .AGEBITS(AGEBITS)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_note_on     (cmd_note_on),
    .cmd_note        (cmd_note),
    .cmd_increment   (cmd_increment),
    .cmd_waveform    (cmd_waveform),
    .voice_increment (voice_increment),
    .voice_select    (voice_select),
    .voice_gate      (voice_gate),
    .drop            (drop),
    .dbg_state       (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 0; m_note[i] = 0; m_inc[i] = 0; m_sel[i] = 0; m_age[i] = 0;
    end
  endtask

  // Apply one command to the model using the allocation rules directly
  task automatic model_cmd(input bit on, input int note, input int inc, input int wf,
                           output bit dropped);
    int tgt;
    dropped = 0;
    tgt = -1;
    if (on) begin
      for (int i = 0; i < NV; i++) if (tgt < 0 && m_gate[i] && m_note[i] == note) tgt = i;
      for (int i = 0; i < NV; i++) if (tgt < 0 && !m_gate[i]) tgt = i;
      if (tgt < 0) begin
`ifdef AUDIO_VOICE_STEAL_EN
        for (int i = 0; i < NV; i++) if (tgt < 0 || m_age[i] > m_age[tgt]) tgt = i;
`else
        dropped = 1;
`endif
      end
      if (tgt >= 0) begin
        for (int i = 0; i < NV; i++)
          if (i != tgt && m_gate[i] && m_age[i] < MAXAGE) m_age[i]++;
        m_gate[tgt] = 1; m_note[tgt] = note; m_inc[tgt] = inc;
        m_sel[tgt] = wf; m_age[tgt] = 0;
      end
    end else begin
      for (int i = 0; i < NV; i++)
        if (m_gate[i] && m_note[i] == note) begin
          m_gate[i] = 0; m_sel[i] = 0;
        end
    end
  endtask

  task automatic model_vectors(output logic [NV-1:0] g, output logic [4*NV-1:0] s,
                               output logic [16*NV-1:0] inc);
    for (int i = 0; i < NV; i++) begin
      g[i]          = m_gate[i];
      s[4*i +: 4]   = 4'(m_sel[i]);
      inc[16*i +: 16] = 16'(m_inc[i]);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NV-1:0]    g;
    logic [4*NV-1:0]  s;
    logic [16*NV-1:0] inc;
    model_vectors(g, s, inc);
    check({tag, "_gate"}, voice_gate, g);
    check({tag, "_sel"}, voice_select, s);
    check({tag, "_inc"}, voice_increment, inc);
  endtask

  task automatic randomize_fields();
    cmd_note_on   = 1'($urandom_range(0, 1));
    cmd_note      = 7'($urandom_range(0, 127));
    cmd_increment = 16'($urandom);
    cmd_waveform  = 4'($urandom_range(0, 15));
  endtask

  // Reset, optionally with a competing handshake that must be refused
  task automatic do_reset(input bit with_valid);
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = with_valid;
    randomize_fields();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0;
    model_reset();
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_drop", drop, 1'b0);
    check_outputs("rst");
    @(negedge clk);
    check("rst_ready_next", cmd_ready, 1'b1);
  endtask

  // Driver: issue one command, garble inputs while busy, check the commit
  task automatic send_cmd(input bit on, input int note, input int inc, input int wf);
    int waited;
    bit exp_drop;
    logic [NV-1:0]    pg;
    logic [4*NV-1:0]  ps;
    logic [16*NV-1:0] pinc;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) check("ready_timeout", cmd_ready, 1'b1);
    model_vectors(pg, ps, pinc);
    cmd_valid     = 1'b1;
    cmd_note_on   = on;
    cmd_note      = 7'(note);
    cmd_increment = 16'(inc);
    cmd_waveform  = 4'(wf);
    @(posedge clk);
    model_cmd(on, note, inc, wf, exp_drop);
    for (int k = 0; k <= NV; k++) begin
      @(negedge clk);
      check("ready_busy", cmd_ready, 1'b0);
      check("drop_busy", drop, 1'b0);
      if (k == NV) begin
        check("hold_gate", voice_gate, pg);
        check("hold_sel", voice_select, ps);
        check("hold_inc", voice_increment, pinc);
      end
      cmd_valid = 1'($urandom_range(0, 1));
      randomize_fields();
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("ready_done", cmd_ready, 1'b1);
    check("drop_commit", drop, exp_drop);
    check_outputs("commit");
    @(negedge clk);
    check("drop_clear", drop, 1'b0);
  endtask

  // Stimulus and final report
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_note_on = 1'b0;
    cmd_note = '0;
    cmd_increment = '0;
    cmd_waveform = '0;
    model_reset();
    repeat (3) @(posedge clk);
    do_reset(1'b1);

    // Single note-on lands on voice 0
    send_cmd(1, 60, 16'h0400, 4'b0001);
    check("first_gate0", voice_gate[0], 1'b1);
    check("first_inc0", voice_increment[15:0], 16'h0400);
    check("first_sel0", voice_select[3:0], 4'b0001);

    // Chord then release the middle note
    do_reset(1'b0);
    send_cmd(1, 60, 16'h0100, 4'd1);
    send_cmd(1, 64, 16'h0200, 4'd2);
    send_cmd(1, 67, 16'h0300, 4'd3);
    send_cmd(0, 64, 16'h0000, 4'd0);
    check("chord_gate", voice_gate, 4'b0101);
    check("chord_sel1", voice_select[7:4], 4'd0);
    check("chord_inc1", voice_increment[31:16], 16'h0200);

    // Retrigger reuses the same voice
    do_reset(1'b0);
    send_cmd(1, 60, 16'h0400, 4'd1);
    send_cmd(1, 60, 16'h0800, 4'd1);
    check("retrig_gate", voice_gate, 4'b0001);
    check("retrig_inc0", voice_increment[15:0], 16'h0800);

    // All voices busy
    do_reset(1'b0);
    send_cmd(1, 60, 60 * 16, 4'd1);
    send_cmd(1, 62, 62 * 16, 4'd2);
    send_cmd(1, 64, 64 * 16, 4'd3);
    send_cmd(1, 65, 65 * 16, 4'd4);
    send_cmd(1, 67, 67 * 16, 4'd5);
`ifdef AUDIO_VOICE_STEAL_EN
    check("steal_inc0", voice_increment[15:0], 16'h0430);
`else
    check("nosteal_inc0", voice_increment[15:0], 16'h03C0);
`endif

    // Reset during SCAN abandons the command
    do_reset(1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_note_on = 1'b1; cmd_note = 7'd60;
    cmd_increment = 16'h0400; cmd_waveform = 4'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("scanrst_ready", cmd_ready, 1'b1);
    check_outputs("scanrst");
    repeat (NV + 2) @(negedge clk);
    check_outputs("scanrst_late");
    check("scanrst_drop", drop, 1'b0);

    // Note-off with nothing gated
    send_cmd(0, 50, 0, 0);

    // Randomized commands
    for (int n = 0; n < 160; n++) begin
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(0, 1) == 1);
      send_cmd($urandom_range(0, 9) < 6, $urandom_range(60, 65),
               ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 65535),
               $urandom_range(1, 15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
